golden_nonce_collector: RTL and testbench
=========================================

Name: golden_nonce_collector

Overview:
- Multi-core successor to the single-core golden-ticket check in the miner top level.
- Takes per-cycle result strobes from CORES parallel double-SHA-256 pipelines and tests each hash2 MSW against a runtime difficulty (leading-zero count).
- Adjusts each hit's nonce and arbitrates simultaneous hits round-robin into a show-ahead FIFO, drained over a valid/ready handshake by the comms/UART layer.
- Sits between the hasher array and the host interface; replaces the single golden_nonce register.

Parameters:
CORES, 4, number of hasher cores (1..16)
CORE_LOG2, 2, ceil(log2(CORES)), minimum 1
FIFO_LOG2, 3, FIFO depth = 2**FIFO_LOG2 entries
NONCE_ADJUST, 32'd129, pipeline offset subtracted from the reported nonce (per LOOP setting of the cores)

Ports:
clk  in  1  hash clock; the block's only clock
reset_n  in  1  asynchronous, active-low reset
work_restart  in  1  synchronous flush of in-flight hits (new work loaded)
target_zeros  in  6  required leading zero bits of hash2[255:224]; values >32 treated as 32
core_valid  in  CORES  per-core hash2_valid strobe
core_hash_msw  in  32*CORES  per-core hash2[255:224], core i at [32i+31:32i]
core_nonce  in  32*CORES  per-core nonce counter value in the cycle of core_valid
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head entry
out_nonce  out  32  adjusted golden nonce at FIFO head
out_core  out  CORE_LOG2  originating core index at FIFO head
fifo_count  out  FIFO_LOG2+1  current occupancy
overflow_cnt  out  16  saturating count of dropped hits
found_total  out  32  wrapping count of FIFO pushes

Behaviour:
- Reset (reset_n low, async): pending bits, FIFO pointers/count, rr pointer, overflow_cnt and found_total all 0. out_valid=0, out_nonce=0, out_core=0.
- Hit test (combinational, per core i): hit_i = core_valid[i] & (top min(target_zeros,32) bits of msw_i all zero). target_zeros=0 means every valid is a hit.
- Pending stage: one slot per core holding {nonce_i - NONCE_ADJUST mod 2^32}.
  - On a clock edge, a hit loads the slot if the slot is empty or is granted in that same cycle.
  - Otherwise the hit is dropped and overflow_cnt increments. Multiple drops in one cycle add that many; the count saturates at 16'hFFFF.
- Arbiter: round-robin over set pending bits, starting at rr pointer. At most one grant per cycle, only when the FIFO can accept.
  - On a grant, the slot clears, the entry {nonce, core index} is pushed, and rr becomes granted index+1 (mod CORES).
  - No grant leaves rr unchanged.
- FIFO accept rule: push allowed if count < depth, or if a pop occurs in the same cycle (full + pop + push keeps count at depth).
- Pop: out_valid & out_ready. out_nonce/out_core are show-ahead and stay stable while out_valid & !out_ready.
- Latency: hit sampled at edge N enters pending; earliest push at edge N+1; out_valid high after edge N+1 (2 cycles, no contention).
- found_total increments on each push and wraps.
- work_restart (sync, priority over everything except reset): clears pending bits and FIFO (count 0, out_valid 0 next cycle).
  - Hits arriving in the same cycle are discarded and not counted as overflow.
  - rr, overflow_cnt and found_total are retained.
- target_zeros may change any cycle; it applies to hits sampled at that edge.

Decomposition:
- Shared package: NONCE_W=32, MSW_W=32, counter widths, and the function leading-zero mask from target_zeros.
- Natural sub-module: nonce_fifo (parameterised show-ahead sync FIFO with count, simultaneous push/pop on full).
- Arbiter and pending slots stay inline.

Test Plan:
- Single hit: core 2 valid, msw=32'h0000_1234, target_zeros=16, nonce=32'd1000 -> 2 cycles later out_valid=1, out_nonce=871, out_core=2, found_total=1.
- Threshold: target_zeros=20, msw=32'h0000_1234 -> no push. target_zeros=19 -> push. target_zeros=40 with msw=0 -> push. msw=1 with target_zeros=40 -> no push.
- Contention: all 4 cores hit in one cycle, out_ready=1 -> pops in order cores 0,1,2,3 on consecutive cycles; rr returns to 0.
- Backpressure/full: out_ready=0, 8 single hits, then core 1 hits twice while its slot is blocked -> fifo_count=8, overflow_cnt=1. Raising out_ready with a same-cycle push keeps fifo_count=8.
- Restart: 3 entries queued plus 2 pending, then work_restart pulse with a concurrent hit -> next cycle fifo_count=0, out_valid=0, no later push; found_total and overflow_cnt unchanged.
- Async reset mid-drain: reset_n low between edges -> out_valid, counters and fifo_count read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/golden_nonce_collector_pkg.sv
// Shared widths and the difficulty mask helper for the golden nonce collector.
package golden_nonce_collector_pkg;

   localparam int NONCE_W = 32;
   localparam int MSW_W   = 32;
   localparam int TZ_W    = 6;
   localparam int OVF_W   = 16;
   localparam int FOUND_W = 32;

   // Mask covering the top min(tz, 32) bits of the hash MSW; tz=0 gives an empty mask.
   function automatic logic [MSW_W-1:0] zero_mask(input logic [TZ_W-1:0] tz);
      logic [TZ_W-1:0] n;
      n = (tz > TZ_W'(MSW_W)) ? TZ_W'(MSW_W) : tz;
      return ~({MSW_W{1'b1}} >> n);
   endfunction

endpackage

// File: rtl/golden_nonce_collector_nonce_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push on full is legal alongside a pop.
module nonce_fifo #(
   parameter int W    = 34,
   parameter int LOG2 = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic          valid,
   output logic [W-1:0]  dout,
   output logic [LOG2:0] count
);

   localparam int DEPTH = 2**LOG2;

   logic [W-1:0]      mem [DEPTH];
   logic [LOG2-1:0]   wr_ptr, rd_ptr;
   logic              pop_ok, push_ok;

   assign valid   = (count != '0);
   assign pop_ok  = pop & valid;
   assign push_ok = push & ((count != (LOG2+1)'(DEPTH)) | pop_ok);
   // Head is forced to zero when empty so the outputs read 0 out of reset.
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (LOG2+1)'(push_ok) - (LOG2+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok & ~flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/golden_nonce_collector.sv
// Multi-core golden nonce collector: difficulty test, per-core pending slots,
// round-robin arbitration into a show-ahead FIFO drained by the host interface.
module golden_nonce_collector
   import golden_nonce_collector_pkg::*;
#(
   parameter int                 CORES        = 4,
   parameter int                 CORE_LOG2    = 2,
   parameter int                 FIFO_LOG2    = 3,
   parameter logic [NONCE_W-1:0] NONCE_ADJUST = 32'd129
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       work_restart,
   input  logic [TZ_W-1:0]            target_zeros,
   input  logic [CORES-1:0]           core_valid,
   input  logic [MSW_W*CORES-1:0]     core_hash_msw,
   input  logic [NONCE_W*CORES-1:0]   core_nonce,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NONCE_W-1:0]         out_nonce,
   output logic [CORE_LOG2-1:0]       out_core,
   output logic [FIFO_LOG2:0]         fifo_count,
   output logic [OVF_W-1:0]           overflow_cnt,
   output logic [FOUND_W-1:0]         found_total
);

   localparam int DEPTH = 2**FIFO_LOG2;
   localparam int ENT_W = NONCE_W + CORE_LOG2;

   logic [MSW_W-1:0]     mask;
   logic [CORES-1:0]     hit, pending, grant, drop;
   logic [NONCE_W-1:0]   slot [CORES];
   logic [CORE_LOG2-1:0] rr, gidx;
   logic [CORE_LOG2:0]   idx;
   logic                 gvalid, pop, push, can_push;
   logic [4:0]           ndrop;
   logic [OVF_W:0]       ovf_sum;
   logic [ENT_W-1:0]     head;

   assign mask = zero_mask(target_zeros);

   always_comb begin
      hit = '0;
      for (int i = 0; i < CORES; i++)
         hit[i] = core_valid[i] & ((core_hash_msw[i*MSW_W +: MSW_W] & mask) == '0);
   end

   // Round-robin search starting at rr; first set pending bit wins.
   always_comb begin
      gvalid = 1'b0;
      gidx   = '0;
      idx    = '0;
      for (int k = 0; k < CORES; k++) begin
         idx = {1'b0, rr} + (CORE_LOG2+1)'(k);
         if (idx >= (CORE_LOG2+1)'(CORES)) idx = idx - (CORE_LOG2+1)'(CORES);
         if (!gvalid && pending[idx[CORE_LOG2-1:0]]) begin
            gvalid = 1'b1;
            gidx   = idx[CORE_LOG2-1:0];
         end
      end
   end

   assign pop      = out_valid & out_ready;
   assign can_push = (fifo_count < (FIFO_LOG2+1)'(DEPTH)) | pop;
   assign push     = gvalid & can_push & ~work_restart;

   always_comb begin
      grant = '0;
      if (push) grant[gidx] = 1'b1;
   end

   // A hit is lost only when its slot is still occupied and not being granted.
   assign drop = work_restart ? '0 : (hit & pending & ~grant);

   always_comb begin
      ndrop = '0;
      for (int i = 0; i < CORES; i++) ndrop = ndrop + 5'(drop[i]);
   end

   assign ovf_sum = {1'b0, overflow_cnt} + (OVF_W+1)'(ndrop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending      <= '0;
         rr           <= '0;
         overflow_cnt <= '0;
         found_total  <= '0;
      end else begin
         pending      <= work_restart ? '0 : ((pending & ~grant) | hit);
         overflow_cnt <= ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
         found_total  <= found_total + FOUND_W'(push);
         if (push) rr <= (gidx == CORE_LOG2'(CORES-1)) ? '0 : gidx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CORES; i++)
         if (hit[i] & ~drop[i] & ~work_restart)
            slot[i] <= core_nonce[i*NONCE_W +: NONCE_W] - NONCE_ADJUST;
   end

   nonce_fifo #(.W(ENT_W), .LOG2(FIFO_LOG2)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (work_restart),
      .push    (push),
      .din     ({slot[gidx], gidx}),
      .pop     (pop),
      .valid   (out_valid),
      .dout    (head),
      .count   (fifo_count)
   );

   assign out_nonce = head[ENT_W-1:CORE_LOG2];
   assign out_core  = head[CORE_LOG2-1:0];

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Bench for golden_nonce_collector: vector table, corner sequences and a randomized run
// checked every cycle against a queue-based reference model.
module tb_golden_nonce_collector;

   localparam int CORES = 4;
   localparam int CL    = 2;
   localparam int FL    = 3;
   localparam int DEPTH = 8;
   localparam logic [31:0] ADJ = 32'd129;

   logic                  clk = 1'b0, reset_n = 1'b0, work_restart = 1'b0, out_ready = 1'b0;
   logic [5:0]            target_zeros = '0;
   logic [CORES-1:0]      core_valid = '0;
   logic [32*CORES-1:0]   core_hash_msw = '0, core_nonce = '0;
   logic                  out_valid;
   logic [31:0]           out_nonce;
   logic [CL-1:0]         out_core;
   logic [FL:0]           fifo_count;
   logic [15:0]           overflow_cnt;
   logic [31:0]           found_total;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   golden_nonce_collector #(.CORES(CORES), .CORE_LOG2(CL), .FIFO_LOG2(FL), .NONCE_ADJUST(ADJ)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .work_restart  (work_restart),
      .target_zeros  (target_zeros),
      .core_valid    (core_valid),
      .core_hash_msw (core_hash_msw),
      .core_nonce    (core_nonce),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_nonce     (out_nonce),
      .out_core      (out_core),
      .fifo_count    (fifo_count),
      .overflow_cnt  (overflow_cnt),
      .found_total   (found_total)
   );

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] nonce; int core; } ent_t;
   ent_t        mq[$];
   bit          mpend [CORES];
   logic [31:0] mslot [CORES];
   int          mrr;
   logic [31:0] mfound;
   int          movf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      mrr = 0; mfound = '0; movf = 0;
   endtask

   function automatic bit is_hit(input int i);
      int tz = (target_zeros > 32) ? 32 : int'(target_zeros);
      logic [31:0] m = core_hash_msw[32*i +: 32];
      if (!core_valid[i]) return 1'b0;
      if (tz == 0) return 1'b1;
      return (m >> (32 - tz)) == 32'd0;
   endfunction

   task automatic model_step();
      bit pop;
      int g, drops;
      pop = (mq.size() > 0) && out_ready;
      if (work_restart) begin
         foreach (mpend[i]) mpend[i] = 1'b0;
         mq.delete();
         return;
      end
      g = -1;
      for (int k = 0; k < CORES; k++)
         if (g < 0 && mpend[(mrr + k) % CORES]) g = (mrr + k) % CORES;
      if (pop) void'(mq.pop_front());
      if (g >= 0 && mq.size() < DEPTH) begin
         mq.push_back('{mslot[g], g});
         mpend[g] = 1'b0;
         mrr = (g + 1) % CORES;
         mfound++;
      end
      drops = 0;
      for (int i = 0; i < CORES; i++) begin
         if (is_hit(i)) begin
            if (mpend[i]) drops++;
            else begin
               mpend[i] = 1'b1;
               mslot[i] = core_nonce[32*i +: 32] - ADJ;
            end
         end
      end
      movf = (movf + drops > 65535) ? 65535 : movf + drops;
   endtask

   task automatic compare();
      chk("out_valid",    32'(out_valid),    32'(mq.size() > 0));
      chk("fifo_count",   32'(fifo_count),   32'(mq.size()));
      chk("found_total",  found_total,       mfound);
      chk("overflow_cnt", 32'(overflow_cnt), 32'(movf));
      if (mq.size() > 0) begin
         chk("out_nonce", out_nonce,       mq[0].nonce);
         chk("out_core",  32'(out_core),   32'(mq[0].core));
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic clear_in();
      core_valid = '0;
      core_hash_msw = '1;
      core_nonce = '0;
   endtask

   task automatic set_hit(input int c, input logic [31:0] msw, input logic [31:0] nonce);
      core_valid[c] = 1'b1;
      core_hash_msw[32*c +: 32] = msw;
      core_nonce[32*c +: 32] = nonce;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          core;
      logic [5:0]  tz;
      logic [31:0] msw;
      logic [31:0] nonce;
      bit          push;
      logic [31:0] exp_nonce;
   } vec_t;
   vec_t vecs [7];

   int exp_found;

   initial begin
      vecs[0] = '{2, 6'd16, 32'h0000_1234, 32'd1000, 1'b1, 32'd871};
      vecs[1] = '{2, 6'd20, 32'h0000_1234, 32'd5,    1'b0, 32'd0};
      vecs[2] = '{2, 6'd19, 32'h0000_1234, 32'd129,  1'b1, 32'd0};
      vecs[3] = '{1, 6'd40, 32'h0000_0000, 32'd50,   1'b1, 32'hFFFF_FFB1};
      vecs[4] = '{3, 6'd40, 32'h0000_0001, 32'd7,    1'b0, 32'd0};
      vecs[5] = '{0, 6'd0,  32'hFFFF_FFFF, 32'd200,  1'b1, 32'd71};
      vecs[6] = '{3, 6'd32, 32'h0000_0000, 32'd128,  1'b1, 32'hFFFF_FFFF};

      model_reset();
      clear_in();
      #12;
      chk("reset_valid", 32'(out_valid),    32'd0);
      chk("reset_nonce", out_nonce,         32'd0);
      chk("reset_core",  32'(out_core),     32'd0);
      chk("reset_count", 32'(fifo_count),   32'd0);
      chk("reset_ovf",   32'(overflow_cnt), 32'd0);
      chk("reset_found", found_total,       32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Threshold / single-hit vectors: push visible two edges after the hit.
      exp_found = 0;
      out_ready = 1'b1;
      foreach (vecs[n]) begin
         clear_in();
         target_zeros = vecs[n].tz;
         set_hit(vecs[n].core, vecs[n].msw, vecs[n].nonce);
         cycle();
         clear_in();
         cycle();
         chk("vec_valid", 32'(out_valid), 32'(vecs[n].push));
         if (vecs[n].push) begin
            chk("vec_nonce", out_nonce, vecs[n].exp_nonce);
            chk("vec_core",  32'(out_core), 32'(vecs[n].core));
         end
         exp_found += int'(vecs[n].push);
         chk("vec_found", found_total, 32'(exp_found));
         cycle();
         cycle();
      end

      // Contention: all cores hit at once, drained in core order.
      target_zeros = 6'd8;
      clear_in();
      for (int c = 0; c < CORES; c++) set_hit(c, 32'h00AB_CDEF, 32'(2000 + c));
      cycle();
      clear_in();
      for (int c = 0; c < CORES; c++) begin
         cycle();
         chk("rr_order_core",  32'(out_core), 32'(c));
         chk("rr_order_nonce", out_nonce,     32'(2000 + c) - ADJ);
      end
      cycle();
      set_hit(1, 32'h0, 32'd2101);
      set_hit(3, 32'h0, 32'd2103);
      cycle();
      clear_in();
      cycle();
      chk("rr_wrap_core", 32'(out_core), 32'd1);
      repeat (3) cycle();
      exp_found += 6;

      // Backpressure: fill the FIFO, then block core 1's slot and drop its second hit.
      out_ready = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         clear_in();
         set_hit(0, 32'h0, 32'(3000 + j));
         cycle();
      end
      clear_in();
      cycle();
      chk("full_count", 32'(fifo_count), 32'd8);
      set_hit(1, 32'h0, 32'd4000);
      cycle();
      cycle();
      clear_in();
      cycle();
      chk("full_ovf",    32'(overflow_cnt), 32'd1);
      chk("full_count2", 32'(fifo_count),   32'd8);
      out_ready = 1'b1;
      cycle();
      chk("full_popush_count", 32'(fifo_count), 32'd8);
      chk("full_popush_head",  out_nonce,       32'd3001 - ADJ);
      repeat (10) cycle();
      exp_found += 9;

      // Restart: 3 queued, 2 pending, then restart with concurrent hits.
      out_ready = 1'b0;
      clear_in();
      for (int c = 0; c < 3; c++) set_hit(c, 32'h0, 32'(5000 + c));
      cycle();
      clear_in();
      cycle();
      cycle();
      set_hit(0, 32'h0, 32'd5100);
      set_hit(3, 32'h0, 32'd5103);
      cycle();
      chk("rst_pre_count", 32'(fifo_count), 32'd3);
      exp_found += 3;
      clear_in();
      set_hit(1, 32'h0, 32'd5201);
      set_hit(0, 32'h0, 32'd5202);
      work_restart = 1'b1;
      cycle();
      work_restart = 1'b0;
      clear_in();
      chk("rst_count", 32'(fifo_count),   32'd0);
      chk("rst_valid", 32'(out_valid),    32'd0);
      chk("rst_found", found_total,       32'(exp_found));
      chk("rst_ovf",   32'(overflow_cnt), 32'd1);
      repeat (3) cycle();
      chk("rst_no_push", 32'(fifo_count), 32'd0);

      // Asynchronous reset in the middle of a drain.
      out_ready = 1'b1;
      for (int c = 0; c < CORES; c++) set_hit(c, 32'h0, 32'(6000 + c));
      cycle();
      clear_in();
      cycle();
      #3;
      reset_n = 1'b0;
      #1;
      chk("areset_valid", 32'(out_valid),    32'd0);
      chk("areset_count", 32'(fifo_count),   32'd0);
      chk("areset_ovf",   32'(overflow_cnt), 32'd0);
      chk("areset_found", found_total,       32'd0);
      chk("areset_nonce", out_nonce,         32'd0);
      chk("areset_core",  32'(out_core),     32'd0);
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         clear_in();
         for (int c = 0; c < CORES; c++)
            if ($urandom_range(0, 2) == 0)
               set_hit(c, $urandom >> $urandom_range(0, 32), $urandom);
         target_zeros = 6'($urandom_range(0, 40));
         out_ready    = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         work_restart = ($urandom_range(0, 50) == 0);
         cycle();
      end
      work_restart = 1'b0;

      // Overflow saturation: FIFO full, every core hits every cycle.
      out_ready = 1'b0;
      target_zeros = 6'd0;
      for (int n = 0; n < 16400; n++) begin
         clear_in();
         for (int c = 0; c < CORES; c++) set_hit(c, $urandom, $urandom);
         cycle();
      end
      chk("ovf_saturate", 32'(overflow_cnt), 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
